// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared types for the hex entry / display path.
//   hex_t       - one hex digit
//   cmd_t       - buffer command decoded from the keypad strobes
//   encode_cmd  - priority encoder, clr > en > bksp
package hex_disp_pkg;

  typedef logic [3:0] hex_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_CLR  = 2'd1,
    CMD_PUSH = 2'd2,
    CMD_BKSP = 2'd3
  } cmd_t;

  function automatic cmd_t encode_cmd(input logic clr, input logic en, input logic bksp);
    if (clr)       return CMD_CLR;
    else if (en)   return CMD_PUSH;
    else if (bksp) return CMD_BKSP;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: free-running display refresh timing.
//   clk, reset - system clock, async active-high reset
//   scan_idx   - index of the digit currently driven
//   scan_sel   - registered one-hot select matching scan_idx
// The index advances once every REFRESH_DIV clocks and wraps after NUM_DIGITS-1.
module digit_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic [NUM_DIGITS-1:0]         scan_sel
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [RW-1:0] refresh_cnt;
  logic          wrap;
  logic [IW-1:0] next_idx;

  assign wrap     = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign next_idx = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      scan_sel    <= NUM_DIGITS'(1);
    end else begin
      if (wrap) begin
        refresh_cnt <= '0;
        scan_idx    <= next_idx;
        scan_sel    <= NUM_DIGITS'(1) << next_idx;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_digit_buffer.sv
// hex_digit_buffer: N-digit hex entry buffer with multiplexed display scan.
//   clk, reset        - system clock, async active-high reset
//   en / bksp / clr   - single-cycle push / backspace / clear strobes
//   hexVal            - nibble pushed as the newest (rightmost) digit
//   digits            - all stored digits, digit 0 in bits [3:0]
//   count, valid_mask - number of entered digits and its thermometer mask
//   overflow          - one-cycle pulse when a push drops a valid digit
//   scan_sel/hex/blank- currently scanned digit select, value, blank flag
module hex_digit_buffer
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV   = 1024,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             bksp,
  input  logic                             clr,
  input  logic [3:0]                       hexVal,
  output logic [4*NUM_DIGITS-1:0]          digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  count,
  output logic [NUM_DIGITS-1:0]            valid_mask,
  output logic                             overflow,
  output logic [NUM_DIGITS-1:0]            scan_sel,
  output logic [3:0]                       scan_hex,
  output logic                             scan_blank
);

  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  hex_t [NUM_DIGITS-1:0] digit_q;
  logic [IW-1:0]         scan_idx;
  cmd_t                  cmd;

  assign cmd    = encode_cmd(clr, en, bksp);
  assign digits = digit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (cmd)
        CMD_CLR: begin
          digit_q <= '0;
          count   <= '0;
        end
        CMD_PUSH: begin
          digit_q <= {digit_q[NUM_DIGITS-2:0], hex_t'(hexVal)};
          if (count == CW'(NUM_DIGITS)) overflow <= 1'b1;
          else                          count    <= count + 1'b1;
        end
        CMD_BKSP: begin
          if (count != '0) begin
            digit_q <= {hex_t'('0), digit_q[NUM_DIGITS-1:1]};
            count   <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_mask = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      valid_mask[i] = (CW'(i) < count);
  end

  digit_scan_ctrl #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .scan_idx (scan_idx),
    .scan_sel (scan_sel)
  );

  // Combinational from live registers so a push shows without waiting for a refresh.
  assign scan_hex   = digit_q[scan_idx];
  assign scan_blank = BLANK_LEADING && !valid_mask[scan_idx];

endmodule

// File: tb/tb_hex_digit_buffer.sv
// tb_hex_digit_buffer: directed self-checking bench for hex_digit_buffer.
// Two instances (BLANK_LEADING 1 and 0) share all inputs, REFRESH_DIV=4.
module tb_hex_digit_buffer;

  logic        clk = 1'b0;
  logic        reset, en, bksp, clr;
  logic [3:0]  hexVal;

  logic [15:0] digits,  digits0;
  logic [2:0]  count,   count0;
  logic [3:0]  valid_mask, valid_mask0;
  logic        overflow, overflow0;
  logic [3:0]  scan_sel, scan_sel0;
  logic [3:0]  scan_hex, scan_hex0;
  logic        scan_blank, scan_blank0;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;

  always #5 clk = ~clk;

  hex_digit_buffer #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .bksp(bksp), .clr(clr), .hexVal(hexVal),
    .digits(digits), .count(count), .valid_mask(valid_mask), .overflow(overflow),
    .scan_sel(scan_sel), .scan_hex(scan_hex), .scan_blank(scan_blank)
  );

  hex_digit_buffer #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .en(en), .bksp(bksp), .clr(clr), .hexVal(hexVal),
    .digits(digits0), .count(count0), .valid_mask(valid_mask0), .overflow(overflow0),
    .scan_sel(scan_sel0), .scan_hex(scan_hex0), .scan_blank(scan_blank0)
  );

  always @(posedge clk) if (overflow) ovf_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One strobe cycle; returns on the negedge after the sampling posedge.
  task automatic strobe(input logic c, input logic e, input logic b, input logic [3:0] v);
    @(negedge clk);
    clr = c; en = e; bksp = b; hexVal = v;
    @(negedge clk);
    clr = 1'b0; en = 1'b0; bksp = 1'b0; hexVal = 4'h0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digits"}, digits, 16'h0000);
    check({tag, "_count"}, count, 3'd0);
    check({tag, "_mask"}, valid_mask, 4'b0000);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_sel"}, scan_sel, 4'b0001);
    check({tag, "_hex"}, scan_hex, 4'h0);
    check({tag, "_blank1"}, scan_blank, 1'b1);
    check({tag, "_blank0"}, scan_blank0, 1'b0);
  endtask

  logic [3:0] exp_sel   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_hex   [5] = '{4'hB, 4'hA, 4'h0, 4'h0, 4'hB};
  logic       exp_blank [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_sel;
    bit         aligned;

    reset = 1'b1; en = 1'b0; bksp = 1'b0; clr = 1'b0; hexVal = 4'h0;
    #2;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;

    // push 1,2,3
    strobe(0, 1, 0, 4'h1);
    strobe(0, 1, 0, 4'h2);
    strobe(0, 1, 0, 4'h3);
    check("p3_digits", digits, 16'h0123);
    check("p3_count", count, 3'd3);
    check("p3_mask", valid_mask, 4'b0111);
    check("p3_ovf_seen", ovf_cnt, 0);

    // backspace down to empty, last one a no-op
    strobe(0, 0, 1, 4'h0);
    check("bk1_digits", digits, 16'h0012);
    check("bk1_count", count, 3'd2);
    check("bk1_mask", valid_mask, 4'b0011);
    strobe(0, 0, 1, 4'h0);
    check("bk2_digits", digits, 16'h0001);
    check("bk2_count", count, 3'd1);
    strobe(0, 0, 1, 4'h0);
    check("bk3_digits", digits, 16'h0000);
    check("bk3_count", count, 3'd0);
    strobe(0, 0, 1, 4'h0);
    check("bk4_digits", digits, 16'h0000);
    check("bk4_count", count, 3'd0);
    check("bk4_mask", valid_mask, 4'b0000);

    // overflow on the 5th push
    ovf_cnt = 0;
    for (int i = 1; i <= 4; i++) strobe(0, 1, 0, 4'(i));
    check("p4_digits", digits, 16'h1234);
    check("p4_count", count, 3'd4);
    check("p4_mask", valid_mask, 4'b1111);
    check("p4_ovf", overflow, 1'b0);
    strobe(0, 1, 0, 4'h5);
    check("p5_digits", digits, 16'h2345);
    check("p5_count", count, 3'd4);
    check("p5_ovf", overflow, 1'b1);
    @(negedge clk);
    check("p5_ovf_drop", overflow, 1'b0);
    @(negedge clk);
    check("p5_ovf_pulses", ovf_cnt, 1);

    // clear on full buffer: no overflow pulse
    strobe(1, 0, 0, 4'h0);
    check("clr_digits", digits, 16'h0000);
    check("clr_count", count, 3'd0);
    check("clr_ovf", overflow, 1'b0);

    // en + clr -> clear wins
    for (int i = 1; i <= 3; i++) strobe(0, 1, 0, 4'(i));
    check("pre_ec_digits", digits, 16'h0123);
    strobe(1, 1, 0, 4'hA);
    check("ec_digits", digits, 16'h0000);
    check("ec_count", count, 3'd0);

    // en + bksp -> push wins
    strobe(0, 1, 0, 4'h1);
    strobe(0, 1, 0, 4'h2);
    check("pre_eb_digits", digits, 16'h0012);
    strobe(0, 1, 1, 4'hA);
    check("eb_digits", digits, 16'h012A);
    check("eb_count", count, 3'd3);
    check("eb_mask", valid_mask, 4'b0111);

    // scan pattern on 00AB
    strobe(1, 0, 0, 4'h0);
    strobe(0, 1, 0, 4'hA);
    strobe(0, 1, 0, 4'hB);
    check("sc_digits", digits, 16'h00AB);
    check("sc_count", count, 3'd2);
    aligned  = 1'b0;
    prev_sel = scan_sel;
    for (int t = 0; t < 40 && !aligned; t++) begin
      @(negedge clk);
      if (prev_sel == 4'b1000 && scan_sel == 4'b0001) aligned = 1'b1;
      prev_sel = scan_sel;
    end
    check("sc_align", aligned, 1'b1);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("sc_sel_%0d_%0d", p, c), scan_sel, exp_sel[p]);
        check($sformatf("sc_hex_%0d_%0d", p, c), scan_hex, exp_hex[p]);
        check($sformatf("sc_blank1_%0d_%0d", p, c), scan_blank, exp_blank[p]);
        check($sformatf("sc_blank0_%0d_%0d", p, c), scan_blank0, 1'b0);
        check($sformatf("sc_hex0_%0d_%0d", p, c), scan_hex0, exp_hex[p]);
        @(negedge clk);
      end
    end

    // push shows on scan immediately: digit 0 becomes C while selected? check value path
    // async reset between edges
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_state("arst");
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("arst_sel0_%0d", c), scan_sel, 4'b0001);
    end
    @(negedge clk);
    check("arst_sel1", scan_sel, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
